lfsr_step_sequencer: RTL

//  Avalon-MM slave controller that sequences a 32-bit Galois LFSR: seed load, single-step, counted burst, free-run, stop.

---
 rtl/lfsr_ctrl_pkg.sv | 36 +++
 rtl/lfsr_step_sequencer_if.sv | 13 +
 rtl/lfsr_galois_step.sv | 8 +
 rtl/lfsr_step_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR step sequencer: register map, CTRL/STATUS
// bit positions, FSM encoding and reset constants.
package lfsr_ctrl_pkg;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_STATUS = 3'd1;
   localparam logic [2:0] ADDR_COUNT  = 3'd2;
   localparam logic [2:0] ADDR_TAPS   = 3'd3;
   localparam logic [2:0] ADDR_LFSR   = 3'd4;
   localparam logic [2:0] ADDR_DONE_N = 3'd5;
   localparam logic [2:0] ADDR_DIV    = 3'd6;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_LOAD   = 2;
   localparam int CTRL_SINGLE = 3;
   localparam int CTRL_FREE   = 4;
   localparam int CTRL_IRQ_EN = 8;

   localparam int STAT_DONE      = 1;
   localparam int STAT_SEED_ZERO = 2;

   localparam logic [31:0] RESET_SEED_DEF   = 32'h3F60FF91;
   localparam logic [31:0] DEFAULT_TAPS_DEF = 32'h80200003;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FREE = 2'd2
   } state_t;

   function automatic logic [31:0] status_word(state_t st, logic seed_zero, logic done);
      status_word = {26'd0, st, 1'b0, seed_zero, done, (st != ST_IDLE)};
   endfunction

endpackage

// File: rtl/lfsr_step_sequencer_if.sv
// Avalon-MM slave bus bundle for the LFSR step sequencer.
interface lfsr_step_sequencer_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, output chipselect, output write_n, output writedata,
                   input readdata);
   modport slave  (input address, input chipselect, input write_n, input writedata,
                   output readdata);
endinterface

// File: rtl/lfsr_galois_step.sv
// One Galois LFSR shift: right shift, XOR the tap mask when the outgoing bit is 1.
module lfsr_galois_step (
   input  logic [31:0] lfsr,
   input  logic [31:0] taps,
   output logic [31:0] lfsr_next
);
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ taps) : (lfsr >> 1);
endmodule

// File: rtl/lfsr_step_sequencer.sv
// Register-programmed sequencer for a 32-bit Galois LFSR: seed load, single step,
// counted burst, free-run and stop, with a done interrupt.
module lfsr_step_sequencer
   import lfsr_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_SEED   = RESET_SEED_DEF,
   parameter logic [31:0] DEFAULT_TAPS = DEFAULT_TAPS_DEF,
   parameter int          DIV_W        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   lfsr_step_sequencer_if.slave   bus,
   input  logic [31:0]            seed_in,
   output logic [31:0]            lfsr_out,
   output logic                   step_pulse,
   output logic                   irq
);

   state_t             state_r, state_s;
   logic [31:0]        lfsr_r, lfsr_s, taps_r, taps_s, count_r, count_s;
   logic [31:0]        done_n_r, done_n_s, next_lfsr_s, load_val_s;
   logic [DIV_W-1:0]   div_r, div_s, div_cnt_r, div_cnt_s;
   logic               done_r, done_s, seed_zero_r, seed_zero_s, irq_en_r, irq_en_s;
   logic               pend_start_r, pend_start_s;
   logic               wr_s, ctrl_wr_s, stat_wr_s, busy_s, div_zero_s, last_step_s;
   logic               start_s, stop_s, load_s, single_s, free_s;
   logic               done_set_s, done_clr_s, seed_zero_set_s;

   lfsr_galois_step u_step (.lfsr(lfsr_r), .taps(taps_r), .lfsr_next(next_lfsr_s));

   assign wr_s        = bus.chipselect & ~bus.write_n;
   assign ctrl_wr_s   = wr_s & (bus.address == ADDR_CTRL);
   assign stat_wr_s   = wr_s & (bus.address == ADDR_STATUS);
   assign start_s     = ctrl_wr_s & bus.writedata[CTRL_START];
   assign stop_s      = ctrl_wr_s & bus.writedata[CTRL_STOP];
   assign load_s      = ctrl_wr_s & bus.writedata[CTRL_LOAD];
   assign single_s    = ctrl_wr_s & bus.writedata[CTRL_SINGLE];
   assign free_s      = ctrl_wr_s & bus.writedata[CTRL_FREE];
   assign busy_s      = (state_r != ST_IDLE);
   assign div_zero_s  = (div_cnt_r == {DIV_W{1'b0}});
   assign last_step_s = (done_n_r == (count_r - 32'd1));
   assign load_val_s  = (seed_in == 32'd0) ? 32'd1 : seed_in;

   assign lfsr_out   = lfsr_r;
   assign step_pulse = busy_s & div_zero_s;
   assign irq        = done_r & irq_en_r;

   // Next-state: FSM, divider, LFSR stepping, counters and register-file writes.
   always_comb begin
      state_s         = state_r;
      lfsr_s          = lfsr_r;
      div_cnt_s       = div_cnt_r;
      done_n_s        = done_n_r;
      pend_start_s    = 1'b0;
      done_set_s      = 1'b0;
      done_clr_s      = 1'b0;
      seed_zero_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (stop_s) begin
               state_s = ST_IDLE;
            end else if (load_s) begin
               lfsr_s          = load_val_s;
               seed_zero_set_s = (seed_in == 32'd0);
               pend_start_s    = start_s;
            end else if (single_s) begin
               lfsr_s = next_lfsr_s;
            end else if (start_s | pend_start_r) begin
               if (count_r != 32'd0) begin
                  state_s    = ST_RUN;
                  done_clr_s = 1'b1;
                  done_n_s   = 32'd0;
                  div_cnt_s  = div_r;
               end else begin
                  done_set_s = 1'b1;
               end
            end else if (free_s) begin
               state_s   = ST_FREE;
               div_cnt_s = div_r;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN, ST_FREE: begin
            if (stop_s) begin
               state_s = ST_IDLE;
            end else if (div_zero_s) begin
               lfsr_s    = next_lfsr_s;
               div_cnt_s = div_r;
               if (state_r == ST_RUN) begin
                  done_n_s = (done_n_r == 32'hFFFF_FFFF) ? done_n_r : (done_n_r + 32'd1);
                  if (last_step_s) begin
                     state_s    = ST_IDLE;
                     done_set_s = 1'b1;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  state_s = ST_FREE;
               end
            end else begin
               div_cnt_s = div_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // A done set on the same edge as its W1C clear takes precedence.
      done_s      = (done_r & ~(stat_wr_s & bus.writedata[STAT_DONE]) & ~done_clr_s) | done_set_s;
      seed_zero_s = (seed_zero_r & ~(stat_wr_s & bus.writedata[STAT_SEED_ZERO])) | seed_zero_set_s;
      irq_en_s    = ctrl_wr_s ? bus.writedata[CTRL_IRQ_EN] : irq_en_r;
      count_s     = (wr_s & ~busy_s & (bus.address == ADDR_COUNT)) ? bus.writedata : count_r;
      taps_s      = (wr_s & ~busy_s & (bus.address == ADDR_TAPS))  ? bus.writedata : taps_r;
      div_s       = (wr_s & ~busy_s & (bus.address == ADDR_DIV))   ? bus.writedata[DIV_W-1:0] : div_r;
   end

   // State and register file update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         lfsr_r       <= RESET_SEED;
         taps_r       <= DEFAULT_TAPS;
         count_r      <= 32'd0;
         div_r        <= {DIV_W{1'b0}};
         div_cnt_r    <= {DIV_W{1'b0}};
         done_n_r     <= 32'd0;
         done_r       <= 1'b0;
         seed_zero_r  <= 1'b0;
         irq_en_r     <= 1'b0;
         pend_start_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         lfsr_r       <= lfsr_s;
         taps_r       <= taps_s;
         count_r      <= count_s;
         div_r        <= div_s;
         div_cnt_r    <= div_cnt_s;
         done_n_r     <= done_n_s;
         done_r       <= done_s;
         seed_zero_r  <= seed_zero_s;
         irq_en_r     <= irq_en_s;
         pend_start_r <= pend_start_s;
      end
   end

   // Zero-latency read mux.
   always_comb begin
      case (bus.address)
         ADDR_CTRL:   bus.readdata = {23'd0, irq_en_r, 8'd0};
         ADDR_STATUS: bus.readdata = status_word(state_r, seed_zero_r, done_r);
         ADDR_COUNT:  bus.readdata = count_r;
         ADDR_TAPS:   bus.readdata = taps_r;
         ADDR_LFSR:   bus.readdata = lfsr_r;
         ADDR_DONE_N: bus.readdata = done_n_r;
         ADDR_DIV:    bus.readdata = {{(32-DIV_W){1'b0}}, div_r};
         default:     bus.readdata = 32'd0;
      endcase
   end

endmodule
